// File: rtl/atm_pkg.sv
// ATM transaction controller: shared state encoding, also exported on the debug bus.
`default_nettype none

package atm_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE      = 3'd0,
    WAIT_PIN  = 3'd1,
    WAIT_AMT  = 3'd2,
    CHECK_BAL = 3'd3,
    DISPENSE  = 3'd4,
    EJECT     = 3'd5,
    LOCKED    = 3'd6
  } state_t;

endpackage

`default_nettype wire

// File: rtl/atm_timeout_ctr.sv
// Inactivity timer: counts enabled cycles and flags the last tolerated one.
`default_nettype none

module atm_timeout_ctr #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int              CNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] count;

  // Saturates so a stalled consumer never sees the count wrap back to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        count <= '0;
    else if (clr)                   count <= '0;
    else if (en && (count != LAST)) count <= count + 1'b1;
  end

  assign expired = (count == LAST);

endmodule

`default_nettype wire

// File: rtl/atm_txn_ctrl.sv
// ATM transaction controller: PIN retry/lockout, inactivity timeout,
// on-chip balance with debit on dispense, and dispenser ready/ack handshake.
`default_nettype none

module atm_txn_ctrl
  import atm_pkg::*;
#(
  parameter int AMT_W         = 16,
  parameter int MAX_PIN_TRIES = 3,
  parameter int TIMEOUT_CYC   = 64,
  parameter int INIT_BALANCE  = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             card_inserted,
  input  logic             pin_valid,
  input  logic             pin_ok,
  input  logic             amt_valid,
  input  logic [AMT_W-1:0] amount,
  input  logic             dispense_ack,
  input  logic             admin_unlock,
  output logic             dispense_cash,
  output logic [AMT_W-1:0] dispense_amt,
  output logic             eject_card,
  output logic             card_retained,
  output logic             insufficient,
  output logic             timeout,
  output logic [AMT_W-1:0] balance,
  output logic [2:0]       state_o
);

  localparam int               TRY_W    = (MAX_PIN_TRIES > 1) ? $clog2(MAX_PIN_TRIES) : 1;
  localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_PIN_TRIES - 1);
  localparam logic [AMT_W-1:0] INIT_BAL = AMT_W'(INIT_BALANCE);

  state_t           state, next_state;
  logic [TRY_W-1:0] tries;
  logic [AMT_W-1:0] amt_reg;

  logic timer_clr, timer_en, expired;
  logic tries_clr, tries_inc, amt_load, debit, to_pulse, insuf_pulse;

  atm_timeout_ctr #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (timer_clr),
    .en      (timer_en),
    .expired (expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Priority in the wait states: card removal, then strobe, then timeout.
  always_comb begin
    next_state  = state;
    timer_clr   = 1'b1;
    timer_en    = 1'b0;
    tries_clr   = 1'b0;
    tries_inc   = 1'b0;
    amt_load    = 1'b0;
    debit       = 1'b0;
    to_pulse    = 1'b0;
    insuf_pulse = 1'b0;
    case (state)
      IDLE: if (card_inserted) begin
        next_state = WAIT_PIN;
        tries_clr  = 1'b1;
      end
      WAIT_PIN: begin
        if (!card_inserted) next_state = IDLE;
        else if (pin_valid) begin
          if (pin_ok)                 next_state = WAIT_AMT;
          else if (tries == LAST_TRY) next_state = LOCKED;
          else                        tries_inc  = 1'b1;
        end else if (expired) begin
          next_state = EJECT;
          to_pulse   = 1'b1;
        end else begin
          timer_clr = 1'b0;
          timer_en  = 1'b1;
        end
      end
      WAIT_AMT: begin
        if (!card_inserted) next_state = IDLE;
        else if (amt_valid) begin
          next_state = CHECK_BAL;
          amt_load   = 1'b1;
        end else if (expired) begin
          next_state = EJECT;
          to_pulse   = 1'b1;
        end else begin
          timer_clr = 1'b0;
          timer_en  = 1'b1;
        end
      end
      CHECK_BAL: begin
        if ((amt_reg == '0) || (amt_reg > balance)) begin
          next_state  = EJECT;
          insuf_pulse = 1'b1;
        end else begin
          next_state = DISPENSE;
        end
      end
      DISPENSE: if (dispense_ack) begin
        next_state = EJECT;
        debit      = 1'b1;
      end
      EJECT:  if (!card_inserted) next_state = IDLE;
      LOCKED: if (admin_unlock) begin
        next_state = IDLE;
        tries_clr  = 1'b1;
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    dispense_cash = (state == DISPENSE);
    dispense_amt  = (state == DISPENSE) ? amt_reg : '0;
    eject_card    = (state == EJECT);
    card_retained = (state == LOCKED);
    state_o       = state;
  end

  // amount > balance is rejected in CHECK_BAL, so the debit cannot underflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tries        <= '0;
      amt_reg      <= '0;
      balance      <= INIT_BAL;
      insufficient <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      if (tries_clr)      tries <= '0;
      else if (tries_inc) tries <= tries + 1'b1;
      if (amt_load) amt_reg <= amount;
      if (debit)    balance <= balance - amt_reg;
      insufficient <= insuf_pulse;
      timeout      <= to_pulse;
    end
  end

  a_disp_amt: assert property (@(posedge clk) disable iff (rst)
    dispense_cash |-> ((dispense_amt <= balance) && (dispense_amt != '0)));
  a_ack_eject: assert property (@(posedge clk) disable iff (rst)
    ((state == DISPENSE) && dispense_ack) |=> (state == EJECT));
  a_locked_tries: assert property (@(posedge clk) disable iff (rst)
    card_retained |-> (tries == LAST_TRY));
  a_bal_stable: assert property (@(posedge clk) disable iff (rst)
    !((state == DISPENSE) && dispense_ack) |=> $stable(balance));

endmodule

`default_nettype wire

// File: tb/tb_atm_txn_ctrl.sv
// Directed bench for atm_txn_ctrl with hand-computed expectations (default parameters).
`default_nettype none

module tb_atm_txn_ctrl;

  localparam logic [2:0] S_IDLE = 3'd0, S_WPIN = 3'd1, S_WAMT = 3'd2, S_CHK = 3'd3,
                         S_DISP = 3'd4, S_EJ = 3'd5, S_LOCK = 3'd6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        card_inserted = 1'b0, pin_valid = 1'b0, pin_ok = 1'b0, amt_valid = 1'b0;
  logic [15:0] amount = '0;
  logic        dispense_ack = 1'b0, admin_unlock = 1'b0;
  logic        dispense_cash, eject_card, card_retained, insufficient, timeout;
  logic [15:0] dispense_amt, balance;
  logic [2:0]  state_o;

  int checks = 0;
  int errors = 0;

  atm_txn_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .card_inserted (card_inserted),
    .pin_valid     (pin_valid),
    .pin_ok        (pin_ok),
    .amt_valid     (amt_valid),
    .amount        (amount),
    .dispense_ack  (dispense_ack),
    .admin_unlock  (admin_unlock),
    .dispense_cash (dispense_cash),
    .dispense_amt  (dispense_amt),
    .eject_card    (eject_card),
    .card_retained (card_retained),
    .insufficient  (insufficient),
    .timeout       (timeout),
    .balance       (balance),
    .state_o       (state_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Card in, correct PIN, amount entered: leaves the DUT in CHECK_BAL.
  task automatic to_check_bal(input logic [15:0] amt);
    card_inserted = 1'b1;
    tick();
    pin_valid = 1'b1; pin_ok = 1'b1;
    tick();
    pin_valid = 1'b0; pin_ok = 1'b0;
    amt_valid = 1'b1; amount = amt;
    tick();
    amt_valid = 1'b0;
    chk("reach_check_bal", state_o, S_CHK);
  endtask

  initial begin
    // Reset
    tick(); tick();
    chk("rst_state", state_o, S_IDLE);
    chk("rst_balance", balance, 16'd1000);
    chk("rst_outputs", {dispense_cash, eject_card, card_retained, insufficient, timeout}, 5'b0);
    chk("rst_disp_amt", dispense_amt, 16'd0);
    rst = 1'b0;

    // Happy path, amount 200, ack on third dispense cycle
    card_inserted = 1'b1;
    tick();
    chk("hp_wait_pin", state_o, S_WPIN);
    pin_valid = 1'b1; pin_ok = 1'b1;
    tick();
    pin_valid = 1'b0; pin_ok = 1'b0;
    chk("hp_wait_amt", state_o, S_WAMT);
    amt_valid = 1'b1; amount = 16'd200;
    tick();
    amt_valid = 1'b0;
    chk("hp_check_bal", state_o, S_CHK);
    tick();
    chk("hp_latency4_cash", dispense_cash, 1'b1);
    chk("hp_disp_amt", dispense_amt, 16'd200);
    tick();
    chk("hp_cash_c2", dispense_cash, 1'b1);
    tick();
    chk("hp_cash_c3", dispense_cash, 1'b1);
    chk("hp_bal_before_ack", balance, 16'd1000);
    dispense_ack = 1'b1;
    tick();
    dispense_ack = 1'b0;
    chk("hp_eject_state", state_o, S_EJ);
    chk("hp_eject_card", eject_card, 1'b1);
    chk("hp_cash_off", dispense_cash, 1'b0);
    chk("hp_disp_amt_off", dispense_amt, 16'd0);
    chk("hp_balance", balance, 16'd800);
    chk("hp_no_pulses", {insufficient, timeout}, 2'b00);
    tick();
    chk("hp_eject_hold", eject_card, 1'b1);
    card_inserted = 1'b0;
    tick();
    chk("hp_idle", state_o, S_IDLE);
    chk("hp_eject_clear", eject_card, 1'b0);

    // Asynchronous reset in the middle of a dispense
    to_check_bal(16'd100);
    tick();
    chk("rd_dispense", dispense_cash, 1'b1);
    #2;
    rst = 1'b1;
    card_inserted = 1'b0;
    #1;
    chk("rd_state", state_o, S_IDLE);
    chk("rd_cash", dispense_cash, 1'b0);
    chk("rd_disp_amt", dispense_amt, 16'd0);
    chk("rd_balance", balance, 16'd1000);
    tick();
    rst = 1'b0;

    // Amount zero and amount above balance are rejected
    to_check_bal(16'd0);
    tick();
    chk("z_insufficient", insufficient, 1'b1);
    chk("z_state", state_o, S_EJ);
    chk("z_no_cash", dispense_cash, 1'b0);
    tick();
    chk("z_pulse_one_cycle", insufficient, 1'b0);
    card_inserted = 1'b0;
    tick();
    to_check_bal(16'd1001);
    tick();
    chk("o_insufficient", insufficient, 1'b1);
    chk("o_balance", balance, 16'd1000);
    card_inserted = 1'b0;
    tick();
    chk("o_idle", state_o, S_IDLE);

    // Timeout: 64 idle cycles in WAIT_PIN
    card_inserted = 1'b1;
    tick();
    repeat (63) tick();
    chk("to_still_wait", state_o, S_WPIN);
    chk("to_not_yet", timeout, 1'b0);
    tick();
    chk("to_eject", state_o, S_EJ);
    chk("to_pulse", timeout, 1'b1);
    tick();
    chk("to_pulse_end", timeout, 1'b0);
    card_inserted = 1'b0;
    tick();

    // Strobe on the timeout cycle wins; then card pulled in WAIT_AMT
    card_inserted = 1'b1;
    tick();
    repeat (63) tick();
    pin_valid = 1'b1; pin_ok = 1'b1;
    tick();
    pin_valid = 1'b0; pin_ok = 1'b0;
    chk("ts_wait_amt", state_o, S_WAMT);
    chk("ts_no_timeout", timeout, 1'b0);
    card_inserted = 1'b0;
    tick();
    chk("pull_idle", state_o, S_IDLE);
    chk("pull_no_pulses", {insufficient, timeout, eject_card}, 3'b000);
    tick();
    chk("pull_no_pulses_late", {insufficient, timeout}, 2'b00);

    // Three wrong PINs lock the card
    card_inserted = 1'b1;
    tick();
    pin_valid = 1'b1; pin_ok = 1'b0;
    tick();
    chk("wp_try1", state_o, S_WPIN);
    tick();
    chk("wp_try2", state_o, S_WPIN);
    tick();
    chk("wp_locked", state_o, S_LOCK);
    chk("wp_retained", card_retained, 1'b1);
    pin_ok = 1'b1;
    card_inserted = 1'b0;
    tick();
    pin_valid = 1'b0; pin_ok = 1'b0;
    chk("wp_sticky", card_retained, 1'b1);
    admin_unlock = 1'b1;
    tick();
    admin_unlock = 1'b0;
    chk("wp_unlock_idle", state_o, S_IDLE);
    chk("wp_unlock_clear", card_retained, 1'b0);

    // Wrong, wrong, right: no lockout (also proves tries was cleared)
    card_inserted = 1'b1;
    tick();
    pin_valid = 1'b1; pin_ok = 1'b0;
    tick(); tick();
    pin_ok = 1'b1;
    tick();
    pin_valid = 1'b0; pin_ok = 1'b0;
    chk("wwr_wait_amt", state_o, S_WAMT);
    amt_valid = 1'b1; amount = 16'd1000;
    tick();
    amt_valid = 1'b0;
    tick();
    chk("full_disp_amt", dispense_amt, 16'd1000);
    dispense_ack = 1'b1;
    tick();
    dispense_ack = 1'b0;
    chk("full_balance_zero", balance, 16'd0);
    chk("full_no_insuff", insufficient, 1'b0);
    card_inserted = 1'b0;
    tick();
    to_check_bal(16'd1);
    tick();
    chk("empty_insufficient", insufficient, 1'b1);
    chk("empty_no_cash", dispense_cash, 1'b0);
    chk("empty_balance", balance, 16'd0);
    card_inserted = 1'b0;
    tick();
    chk("end_idle", state_o, S_IDLE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
